// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, frame length limits, receive
// write-state encoding and small arithmetic helpers.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1518;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  // Reflected CRC-32 advanced by one byte, least significant bit first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered byte-wide CRC-32 accumulator. clear restarts from the init value;
// clear together with en folds the first byte straight into a fresh CRC.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc32_byte(clear ? CRC32_INIT : crc, data);
    end else if (clear) begin
      crc <= CRC32_INIT;
    end
  end

endmodule

// File: rtl/eth_rx_fcs_filter.sv
// Receive frame filter: buffers each frame speculatively, checks FCS and length,
// commits good frames to a descriptor FIFO and replays them with the FCS stripped.
module eth_rx_fcs_filter
  import eth_pkg::*;
#(
  parameter int BUF_AW  = 11,
  parameter int DESC_AW = 3,
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_eop,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [10:0] out_len,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_crc_err,
  output logic [15:0] cnt_len_err,
  output logic [15:0] cnt_ovf
);

  localparam int LEN_W  = 11;
  localparam int DESC_N = 1 << DESC_AW;
  localparam int BUF_N  = 1 << BUF_AW;

  typedef logic [BUF_AW-1:0] ptr_t;
  typedef logic [LEN_W-1:0]  len_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam len_t LEN_ONE = len_t'(1);
  localparam len_t LEN_SAT = '1;
  localparam len_t MIN_L   = len_t'(MIN_LEN);
  localparam len_t MAX_L   = len_t'(MAX_LEN);
  localparam len_t FCS_L   = len_t'(4);
  localparam logic [DESC_AW:0] DESC_ONE = (DESC_AW+1)'(1);

  // ---------------------------------------------------------------- write side
  wr_state_t wr_state, wr_state_nxt;
  ptr_t      wr_ptr, commit_ptr, rd_ptr, rd_base;
  ptr_t      commit_nxt, base_ptr, wr_addr;
  len_t      len, len_cur, len_inc;
  len_t      eval_len;
  logic      eval_pending, eval_ovf;
  logic      byte_wr, crc_clear, frame_end, end_ovf, buf_full;
  logic      crc_ok, len_bad, eval_good, eval_bad;
  logic      desc_full, desc_empty;
  logic [31:0] crc;

  logic [7:0] buf_mem [BUF_N];
  logic [7:0] ram_q;

  eth_crc32 u_crc (
    .clk   (clk50),
    .rst_n (rst_n),
    .clear (crc_clear),
    .en    (byte_wr),
    .data  (rx_data),
    .crc   (crc)
  );

  // Verdict for the frame that ended last cycle; the next frame may already be
  // starting, so its first byte lands at the post-verdict commit point.
  always_comb begin
    crc_ok     = (crc == CRC32_RESIDUE);
    len_bad    = (eval_len < MIN_L) || (eval_len > MAX_L);
    eval_good  = eval_pending && !eval_ovf && !len_bad && crc_ok && !desc_full;
    eval_bad   = eval_pending && !eval_good;
    commit_nxt = eval_good ? commit_ptr + ptr_t'(eval_len - FCS_L) : commit_ptr;
    base_ptr   = eval_pending ? commit_nxt : wr_ptr;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    byte_wr      = 1'b0;
    crc_clear    = 1'b0;
    frame_end    = 1'b0;
    end_ovf      = 1'b0;
    wr_addr      = (wr_state == IDLE) ? base_ptr : wr_ptr;
    buf_full     = ((wr_addr + PTR_ONE) == rd_base);
    len_cur      = (wr_state == IDLE) ? '0 : len;
    len_inc      = (rx_valid && (len_cur != LEN_SAT)) ? len_cur + LEN_ONE : len_cur;
    unique case (wr_state)
      IDLE: begin
        if (rx_valid) begin
          crc_clear = 1'b1;
          if (buf_full) begin
            wr_state_nxt = DROP;
          end else begin
            byte_wr      = 1'b1;
            wr_state_nxt = RECV;
          end
          if (rx_eop) begin
            frame_end    = 1'b1;
            end_ovf      = (wr_state_nxt == DROP);
            wr_state_nxt = IDLE;
          end
        end
      end
      RECV: begin
        if (rx_valid) begin
          if (buf_full) wr_state_nxt = DROP;
          else          byte_wr      = 1'b1;
        end
        if (rx_eop) begin
          frame_end    = 1'b1;
          end_ovf      = (wr_state_nxt == DROP);
          wr_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (rx_eop) begin
          frame_end    = 1'b1;
          end_ovf      = 1'b1;
          wr_state_nxt = IDLE;
        end
      end
      default: wr_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) wr_state <= IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      len          <= '0;
      eval_pending <= 1'b0;
      eval_len     <= '0;
      eval_ovf     <= 1'b0;
    end else begin
      if (byte_wr)           wr_ptr <= wr_addr + PTR_ONE;
      else if (eval_pending) wr_ptr <= commit_nxt;
      commit_ptr <= commit_nxt;
      if (rx_valid && (wr_state != DROP)) len <= len_inc;
      eval_pending <= frame_end;
      if (frame_end) begin
        eval_len <= len_inc;
        eval_ovf <= end_ovf;
      end
    end
  end

  // ------------------------------------------------------ verdict and counters
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      frame_good  <= 1'b0;
      frame_bad   <= 1'b0;
      cnt_good    <= '0;
      cnt_crc_err <= '0;
      cnt_len_err <= '0;
      cnt_ovf     <= '0;
    end else begin
      frame_good <= eval_good;
      frame_bad  <= eval_bad;
      if (eval_good) cnt_good <= sat_inc16(cnt_good);
      if (eval_bad) begin
        if (eval_ovf)     cnt_ovf     <= sat_inc16(cnt_ovf);
        else if (len_bad) cnt_len_err <= sat_inc16(cnt_len_err);
        else if (!crc_ok) cnt_crc_err <= sat_inc16(cnt_crc_err);
        else              cnt_ovf     <= sat_inc16(cnt_ovf);
      end
    end
  end

  // ---------------------------------------------------------- descriptor FIFO
  logic [DESC_AW:0] desc_wp, desc_rp;
  len_t             desc_mem [DESC_N];
  logic             desc_pop;

  assign desc_empty = (desc_wp == desc_rp);
  assign desc_full  = (desc_wp[DESC_AW] != desc_rp[DESC_AW]) &&
                      (desc_wp[DESC_AW-1:0] == desc_rp[DESC_AW-1:0]);

  always_ff @(posedge clk50) begin
    if (eval_good) desc_mem[desc_wp[DESC_AW-1:0]] <= eval_len - FCS_L;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      desc_wp <= '0;
      desc_rp <= '0;
    end else begin
      if (eval_good) desc_wp <= desc_wp + DESC_ONE;
      if (desc_pop)  desc_rp <= desc_rp + DESC_ONE;
    end
  end

  // ----------------------------------------------------------- frame buffer
  logic rd_issue;

  always_ff @(posedge clk50) begin
    if (byte_wr) buf_mem[wr_addr] <= rx_data;
  end

  always_ff @(posedge clk50) begin
    if (rd_issue) ram_q <= buf_mem[rd_ptr];
  end

  // ---------------------------------------------------------------- read side
  // out_valid/out_ready: a byte transfers on any cycle where both are high;
  // once out_valid rises, out_data/out_last/out_len hold until that transfer.
  logic       rd_active, rd_inflight, rd_inflight_last, out_pop;
  len_t       rd_remain, rd_len;
  logic [7:0] skid_data [2];
  logic       skid_last [2];
  logic       skid_wi, skid_ri;
  logic [1:0] skid_cnt, occ;

  assign out_valid = (skid_cnt != 2'd0);
  assign out_data  = skid_data[skid_ri];
  assign out_last  = out_valid && skid_last[skid_ri];
  assign out_len   = rd_len;
  assign out_pop   = out_valid && out_ready;
  assign desc_pop  = !rd_active && !desc_empty;

  // A read is issued only if its byte is guaranteed a skid slot on arrival.
  always_comb begin
    occ      = skid_cnt + {1'b0, rd_inflight};
    rd_issue = rd_active && (rd_remain != '0) && ((occ != 2'd2) || out_pop);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr           <= '0;
      rd_base          <= '0;
      rd_active        <= 1'b0;
      rd_remain        <= '0;
      rd_len           <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
      skid_wi          <= 1'b0;
      skid_ri          <= 1'b0;
      skid_cnt         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        skid_data[i] <= '0;
        skid_last[i] <= 1'b0;
      end
    end else begin
      if (desc_pop) begin
        rd_active <= 1'b1;
        rd_remain <= desc_mem[desc_rp[DESC_AW-1:0]];
        rd_len    <= desc_mem[desc_rp[DESC_AW-1:0]];
      end
      if (rd_issue) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        rd_remain <= rd_remain - LEN_ONE;
      end
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue && (rd_remain == LEN_ONE);
      if (rd_inflight) begin
        skid_data[skid_wi] <= ram_q;
        skid_last[skid_wi] <= rd_inflight_last;
        skid_wi            <= ~skid_wi;
      end
      if (out_pop) begin
        skid_ri <= ~skid_ri;
        if (skid_last[skid_ri]) begin
          rd_active <= 1'b0;
          rd_base   <= rd_ptr;
        end
      end
      unique case ({rd_inflight, out_pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_filter.sv
// Bench for eth_rx_fcs_filter: frames built with their own FCS, a frame-level
// reference model feeding an expected byte queue, and a per-cycle output monitor.
module tb_eth_rx_fcs_filter;

  logic        clk50    = 1'b0;
  logic        rst_n    = 1'b0;
  logic [7:0]  rx_data  = '0;
  logic        rx_valid = 1'b0;
  logic        rx_eop   = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_last;
  logic [10:0] out_len;
  logic        frame_good, frame_bad;
  logic [15:0] cnt_good, cnt_crc_err, cnt_len_err, cnt_ovf;

  always #10 clk50 = ~clk50;

  eth_rx_fcs_filter dut (
    .clk50       (clk50),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_eop      (rx_eop),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .out_len     (out_len),
    .frame_good  (frame_good),
    .frame_bad   (frame_bad),
    .cnt_good    (cnt_good),
    .cnt_crc_err (cnt_crc_err),
    .cnt_len_err (cnt_len_err),
    .cnt_ovf     (cnt_ovf)
  );

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];          // {payload len, last, data}
  int exp_good, exp_crc, exp_len, exp_ovf;
  int n_good_pulse, n_bad_pulse;
  int ready_mode = 1;             // 0 hold low, 1 hold high, 2 random
  logic [7:0]  frame_bytes [0:2047];
  int          frame_n;
  logic [7:0]  last_byte_seen = '0;
  logic [10:0] last_len_seen  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // FCS is the complemented CRC of the payload, sent low byte first.
  function automatic bit fcs_ok();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frame_n - 4; i++) c = crc_upd(c, frame_bytes[i]);
    c = ~c;
    return c == {frame_bytes[frame_n-1], frame_bytes[frame_n-2],
                 frame_bytes[frame_n-3], frame_bytes[frame_n-4]};
  endfunction

  task automatic build_frame(input int n, input bit ramp, input bit corrupt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      frame_bytes[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
      c = crc_upd(c, frame_bytes[i]);
    end
    c = ~c;
    frame_bytes[n-4] = c[7:0];
    frame_bytes[n-3] = c[15:8];
    frame_bytes[n-2] = c[23:16];
    frame_bytes[n-1] = c[31:24];
    if (corrupt) frame_bytes[n-1][0] = ~frame_bytes[n-1][0];
    frame_n = n;
  endtask

  task automatic model_frame(input bit ovf);
    logic [10:0] plen;
    plen = 11'(frame_n - 4);
    if (ovf) exp_ovf++;
    else if (frame_n < 64 || frame_n > 1518) exp_len++;
    else if (!fcs_ok()) exp_crc++;
    else begin
      exp_good++;
      for (int i = 0; i < frame_n - 4; i++)
        exp_q.push_back({plen, (i == frame_n - 5), frame_bytes[i]});
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_n; i++) begin
      @(posedge clk50); #1;
      rx_valid = 1'b1;
      rx_data  = frame_bytes[i];
      rx_eop   = (i == frame_n - 1);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk50); #1;
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    rx_data  = '0;
    repeat (n) @(posedge clk50);
  endtask

  task automatic wait_drain(input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(posedge clk50);
      k++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (10) @(posedge clk50);
  endtask

  task automatic check_counts();
    repeat (6) @(posedge clk50);
    #1;
    check("cnt_good", cnt_good, exp_good);
    check("cnt_crc_err", cnt_crc_err, exp_crc);
    check("cnt_len_err", cnt_len_err, exp_len);
    check("cnt_ovf", cnt_ovf, exp_ovf);
    check("good_pulses", n_good_pulse, exp_good);
    check("bad_pulses", n_bad_pulse, exp_crc + exp_len + exp_ovf);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_len"}, out_len, 0);
    check({tag, "_frame_good"}, frame_good, 0);
    check({tag, "_frame_bad"}, frame_bad, 0);
    check({tag, "_cnt_good"}, cnt_good, 0);
    check({tag, "_cnt_crc"}, cnt_crc_err, 0);
    check({tag, "_cnt_len"}, cnt_len_err, 0);
    check({tag, "_cnt_ovf"}, cnt_ovf, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk50); #1;
      out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Output monitor: every accepted byte must be the head of the expected queue.
  initial begin
    logic [19:0] e;
    bit prev_hold;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk50);
      if (!rst_n) begin
        n_good_pulse = 0;
        n_bad_pulse  = 0;
        prev_hold    = 1'b0;
      end else begin
        if (frame_good) n_good_pulse++;
        if (frame_bad)  n_bad_pulse++;
        if (prev_hold) check("hold_valid", out_valid, 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %0h with no byte expected at %0t", out_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[7:0]);
            check("out_last", out_last, e[8]);
            check("out_len", out_len, e[19:9]);
            if (out_last) begin
              last_byte_seen = out_data;
              last_len_seen  = out_len;
            end
          end
        end
        prev_hold = out_valid && !out_ready;
      end
    end
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk50);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk50);

    // 1: 64-byte frame with ramp payload
    ready_mode = 1;
    build_frame(64, 1'b1, 1'b0);
    model_frame(1'b0);
    send_frame();
    idle(2);
    wait_drain(500);
    check_counts();
    check("t1_last_byte", last_byte_seen, 8'h3B);
    check("t1_out_len", last_len_seen, 60);
    check("t1_cnt_good", cnt_good, 1);

    // 2: corrupted FCS, then a good frame
    build_frame(64, 1'b1, 1'b1);
    model_frame(1'b0);
    send_frame();
    idle(4);
    check_counts();
    check("t2_cnt_crc", cnt_crc_err, 1);
    build_frame(100, 1'b0, 1'b0);
    model_frame(1'b0);
    send_frame();
    idle(2);
    wait_drain(500);
    check_counts();

    // 3: runt and giant back to back
    build_frame(63, 1'b1, 1'b0);
    model_frame(1'b0);
    send_frame();
    build_frame(1519, 1'b1, 1'b0);
    model_frame(1'b0);
    send_frame();
    idle(4);
    check_counts();
    check("t3_cnt_len", cnt_len_err, 2);

    // 4: consumer stalled, second max frame overflows the buffer
    ready_mode = 0;
    build_frame(1518, 1'b0, 1'b0);
    model_frame(1'b0);
    send_frame();
    idle(3);
    build_frame(1518, 1'b0, 1'b0);
    model_frame(1'b1);
    send_frame();
    idle(3);
    check_counts();
    check("t4_cnt_ovf", cnt_ovf, 1);
    check("t4_cnt_good", cnt_good, 3);
    check("t4_held_valid", out_valid, 1);
    check("t4_held_data", out_data, exp_q[0][7:0]);
    ready_mode = 1;
    wait_drain(3000);
    check_counts();

    // 5: random frames around the pointer wrap, random backpressure
    ready_mode = 2;
    for (int f = 0; f < 15; f++) begin
      int n;
      int kind;
      kind = int'($urandom_range(0, 9));
      n = (kind == 1) ? int'($urandom_range(20, 63)) : int'($urandom_range(64, 400));
      build_frame(n, 1'b0, kind == 0);
      model_frame(1'b0);
      send_frame();
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
      if (f % 3 == 2) begin
        idle(1);
        wait_drain(6000);
      end
    end
    idle(2);
    wait_drain(6000);
    check_counts();

    // 6: reset mid-frame with a committed frame pending
    ready_mode = 0;
    build_frame(100, 1'b0, 1'b0);
    model_frame(1'b0);
    send_frame();
    idle(8);
    check("t6_pre_valid", out_valid, 1);
    build_frame(200, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk50); #1;
      rx_valid = 1'b1;
      rx_data  = frame_bytes[i];
      rx_eop   = 1'b0;
    end
    @(posedge clk50); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    rx_valid = 1'b0;
    rx_data  = '0;
    exp_q.delete();
    exp_good = 0;
    exp_crc  = 0;
    exp_len  = 0;
    exp_ovf  = 0;
    repeat (3) @(posedge clk50);
    #1;
    rst_n = 1'b1;
    ready_mode = 1;
    build_frame(80, 1'b0, 1'b0);
    model_frame(1'b0);
    send_frame();
    idle(2);
    wait_drain(500);
    check_counts();
    check("t6_cnt_good", cnt_good, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
